// File: rtl/instruction_fetch_sequencer.sv
// Program-counter owner and one-entry fetch buffer for the 16-bit CPU front end.
// Optional FETCH_PERF_EN adds saturating accepted-word and stall-cycle counters.
module instruction_fetch_sequencer #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int          MEM_BYTES   = 256,
  parameter logic [15:0] HALT_OPCODE = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  output logic [15:0] instr_out,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_target,
  output logic        halted,
  output logic        fault
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stalls
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [15:0] LAST_PC = 16'(MEM_BYTES - 2);

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] ipc_q, ipc_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  // Set once the halt word is buffered: fetching stops until it is accepted.
  logic        stop_q, stop_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 16'h0000;
      ipc_q   <= 16'h0000;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      stop_q  <= stop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    fault_d = fault_q;
    stop_d  = stop_q;
    unique case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        if (start) begin
          state_d = ST_RUN;
          pc_d    = RESET_PC;
        end
      end
      ST_RUN: begin
        if (redirect_valid) begin
          // Redirect wins over everything, including a same-cycle handshake.
          valid_d = 1'b0;
          stop_d  = 1'b0;
          if (redirect_target[0]) begin
            fault_d = 1'b1;
            state_d = ST_HALT;
          end else begin
            pc_d = redirect_target;
          end
        end else if (stop_q) begin
          if (!valid_q || instr_ready) begin
            valid_d = 1'b0;
            stop_d  = 1'b0;
            state_d = ST_HALT;
          end
        end else if (!valid_q || instr_ready) begin
          // A fetch attempt always empties the buffer, so an out-of-range halt is immediate.
          if (pc_q > LAST_PC) begin
            fault_d = 1'b1;
            valid_d = 1'b0;
            state_d = ST_HALT;
          end else begin
            instr_d = imem_data;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + 16'd2;
            stop_d  = (imem_data == HALT_OPCODE);
          end
        end
      end
      ST_HALT: begin
        valid_d = 1'b0;
        stop_d  = 1'b0;
        if (redirect_valid) begin
          if (redirect_target[0]) begin
            fault_d = 1'b1;
          end else begin
            pc_d    = redirect_target;
            state_d = ST_RUN;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign imem_addr   = pc_q;
  assign instr_out   = instr_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = valid_q;
  assign halted      = (state_q == ST_HALT);
  assign fault       = fault_q;

`ifdef FETCH_PERF_EN
  logic [31:0] fetched_q, stalls_q;
  logic        accept_w;

  // A handshake coinciding with a redirect is discarded, so it is not counted.
  assign accept_w = valid_q && instr_ready && !redirect_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetched_q <= 32'd0;
      stalls_q  <= 32'd0;
    end else begin
      if (accept_w && fetched_q != 32'hFFFF_FFFF) fetched_q <= fetched_q + 32'd1;
      if (valid_q && !instr_ready && stalls_q != 32'hFFFF_FFFF) stalls_q <= stalls_q + 32'd1;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_stalls  = stalls_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Directed bench for instruction_fetch_sequencer: a 256-byte instance for the
// main flow and an 8-byte instance for the out-of-range fault.
module tb_instruction_fetch_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Instance A: 256-byte memory
  logic        rst, start, instr_ready, redirect_valid;
  logic [15:0] redirect_target, imem_addr, imem_data, instr_out, instr_pc;
  logic        instr_valid, halted, fault;
  logic [7:0]  mem_a [0:255];

  // Instance B: 8-byte memory
  logic        rst_b, start_b, ready_b, redir_b;
  logic [15:0] target_b, addr_b, data_b, out_b, pc_b;
  logic        valid_b, halted_b, fault_b;
  logic [7:0]  mem_b [0:7];

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stalls, perf_fetched_b, perf_stalls_b;
`endif

  assign imem_data = {mem_a[imem_addr[7:0]], mem_a[imem_addr[7:0] + 8'd1]};
  assign data_b    = {mem_b[addr_b[2:0]], mem_b[addr_b[2:0] + 3'd1]};

  instruction_fetch_sequencer #(.MEM_BYTES(256)) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .halted(halted), .fault(fault)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_stalls(perf_stalls)
`endif
  );

  instruction_fetch_sequencer #(.MEM_BYTES(8)) u_dut_small (
    .clk(clk), .rst(rst_b), .start(start_b),
    .imem_addr(addr_b), .imem_data(data_b),
    .instr_out(out_b), .instr_pc(pc_b), .instr_valid(valid_b),
    .instr_ready(ready_b), .redirect_valid(redir_b),
    .redirect_target(target_b), .halted(halted_b), .fault(fault_b)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched_b), .perf_stalls(perf_stalls_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_a[i] = 8'h00;
    for (int i = 0; i < 8; i++) mem_b[i] = 8'h00;
    mem_a[0] = 8'h31; mem_a[1] = 8'h12; mem_a[2] = 8'h34; mem_a[3] = 8'h13;
    mem_a[4] = 8'h01; mem_a[5] = 8'h40; mem_a[6] = 8'hFF; mem_a[7] = 8'hFF;
    mem_a[16] = 8'h55; mem_a[17] = 8'h66;
    mem_b[0] = 8'h31; mem_b[1] = 8'h12; mem_b[2] = 8'h34; mem_b[3] = 8'h13;
    mem_b[4] = 8'h01; mem_b[5] = 8'h40; mem_b[6] = 8'hAB; mem_b[7] = 8'hCD;

    rst = 1'b1; start = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_target = 16'h0;
    rst_b = 1'b1; start_b = 1'b0; ready_b = 1'b0; redir_b = 1'b0; target_b = 16'h0;
    step(); step();
    check("rst_valid", 32'(instr_valid), 32'h0);
    check("rst_out", 32'(instr_out), 32'h0);
    check("rst_pc", 32'(instr_pc), 32'h0);
    check("rst_addr", 32'(imem_addr), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_fault", 32'(fault), 32'h0);

    // Start and stream with ready held high
    rst = 1'b0; start = 1'b1; instr_ready = 1'b1;
    step(); start = 1'b0;
    check("start_valid", 32'(instr_valid), 32'h0);
    check("start_addr", 32'(imem_addr), 32'h0);
    step();
    check("w0_out", 32'(instr_out), 32'h3112);
    check("w0_pc", 32'(instr_pc), 32'h0);
    check("w0_addr", 32'(imem_addr), 32'h2);
    step();
    check("w1_out", 32'(instr_out), 32'h3413);
    check("w1_pc", 32'(instr_pc), 32'h2);

    // Three-cycle stall
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_valid", 32'(instr_valid), 32'h1);
      check("stall_out", 32'(instr_out), 32'h3413);
      check("stall_pc", 32'(instr_pc), 32'h2);
      check("stall_addr", 32'(imem_addr), 32'h4);
    end
    instr_ready = 1'b1;
    step();
    check("w2_out", 32'(instr_out), 32'h0140);
    check("w2_pc", 32'(instr_pc), 32'h4);
    check("w2_addr", 32'(imem_addr), 32'h6);

    // Redirect while buffer holds pc 4
    redirect_valid = 1'b1; redirect_target = 16'h0010;
    step(); redirect_valid = 1'b0;
    check("redir_valid", 32'(instr_valid), 32'h0);
    check("redir_addr", 32'(imem_addr), 32'h10);
    step();
    check("redir_out", 32'(instr_out), 32'h5566);
    check("redir_pc", 32'(instr_pc), 32'h10);
    check("redir_valid2", 32'(instr_valid), 32'h1);

    // Run into the halt opcode at 0x0006
    redirect_valid = 1'b1; redirect_target = 16'h0004;
    step(); redirect_valid = 1'b0;
    check("r4_valid", 32'(instr_valid), 32'h0);
    step();
    check("r4_pc", 32'(instr_pc), 32'h4);
    step();
    check("halt_word", 32'(instr_out), 32'hFFFF);
    check("halt_word_pc", 32'(instr_pc), 32'h6);
    check("halt_not_yet", 32'(halted), 32'h0);
    step();
    check("halted", 32'(halted), 32'h1);
    check("halt_valid", 32'(instr_valid), 32'h0);
    check("halt_addr", 32'(imem_addr), 32'h8);
    step();
    check("halt_hold", 32'(halted), 32'h1);
    check("halt_valid2", 32'(instr_valid), 32'h0);

    // Resume from HALT with redirect to 0
    redirect_valid = 1'b1; redirect_target = 16'h0000;
    step(); redirect_valid = 1'b0;
    check("resume_halted", 32'(halted), 32'h0);
    check("resume_addr", 32'(imem_addr), 32'h0);
    step();
    check("refetch_out", 32'(instr_out), 32'h3112);
    check("refetch_pc", 32'(instr_pc), 32'h0);

    // Misaligned redirect
    redirect_valid = 1'b1; redirect_target = 16'h0005;
    step(); redirect_valid = 1'b0;
    check("mis_fault", 32'(fault), 32'h1);
    check("mis_halted", 32'(halted), 32'h1);
    check("mis_valid", 32'(instr_valid), 32'h0);
    check("mis_addr", 32'(imem_addr), 32'h2);

    // Back to RUN (fault sticky), stall, then reset mid-stall
    redirect_valid = 1'b1; redirect_target = 16'h0000;
    step(); redirect_valid = 1'b0; instr_ready = 1'b0;
    check("sticky_fault", 32'(fault), 32'h1);
    step();
    check("pre_rst_valid", 32'(instr_valid), 32'h1);
    step();
    check("pre_rst_out", 32'(instr_out), 32'h3112);
    rst = 1'b1;
    step(); rst = 1'b0;
    check("mrst_valid", 32'(instr_valid), 32'h0);
    check("mrst_addr", 32'(imem_addr), 32'h0);
    check("mrst_fault", 32'(fault), 32'h0);
    check("mrst_halted", 32'(halted), 32'h0);
    check("mrst_out", 32'(instr_out), 32'h0);
    instr_ready = 1'b1;
    step(); step();
    check("idle_valid", 32'(instr_valid), 32'h0);
    check("idle_addr", 32'(imem_addr), 32'h0);

    // Out-of-range fetch on the 8-byte instance
    rst_b = 1'b0; start_b = 1'b1; ready_b = 1'b1;
    step(); start_b = 1'b0;
    step();
    check("b_w0", 32'(out_b), 32'h3112);
    step();
    check("b_w1", 32'(out_b), 32'h3413);
    step();
    check("b_w2", 32'(out_b), 32'h0140);
    step();
    check("b_w3", 32'(out_b), 32'hABCD);
    check("b_w3_pc", 32'(pc_b), 32'h6);
    check("b_w3_fault", 32'(fault_b), 32'h0);
    step();
    check("b_range_fault", 32'(fault_b), 32'h1);
    check("b_range_halted", 32'(halted_b), 32'h1);
    check("b_range_valid", 32'(valid_b), 32'h0);
    check("b_range_addr", 32'(addr_b), 32'h8);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
